sysid_boot_checker: RTL and testbench

- Read-side master stage sitting directly upstream of the system-ID control slave; it drives the slave's 1-bit address and consumes its 32-bit readdata.
- On request, it reads the ID word (address 0) and the build timestamp word (address 1) and compares both against expected values.
- It publishes pass/fail flags and the captured words to the boot/status logic, so firmware-hardware mismatches are flagged before the Nios II software proceeds.

---
 rtl/sysid_check_pkg.sv | 26 ++
 rtl/sysid_period_timer.sv | 29 ++
 rtl/sysid_boot_checker.sv | 141 ++++++++++++++
 tb/tb_sysid_boot_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_check_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MCOUNT_W   = 8;
    localparam int unsigned WAIT_CNT_W = 4;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Result of one completed check, published as a unit at REPORT.
    typedef struct packed {
        logic [DATA_W-1:0] id;
        logic [DATA_W-1:0] ts;
        logic              id_ok;
        logic              ts_ok;
    } check_result_t;

endpackage

// File: rtl/sysid_period_timer.sv
// Free-running period counter; tick pulses for one cycle each time the counter wraps.
module sysid_period_timer #(
    parameter int unsigned CHECK_PERIOD = 1000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (CHECK_PERIOD > 1) ? $clog2(CHECK_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHECK_PERIOD - 1);

    logic [CNT_W-1:0] count;
    logic             wrap_c;

    assign wrap_c = (count == LAST);

    // Count 0..CHECK_PERIOD-1 and register the wrap as a one-cycle tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= wrap_c;
            count <= wrap_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads the system-ID slave (ID word, then build timestamp), compares both
// against expected values and publishes flags, captures and a mismatch count.
// Optional macro SYSID_PERIODIC_CHECK_EN adds an automatic re-check every
// CHECK_PERIOD cycles.
module sysid_boot_checker
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1490127728,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned CHECK_PERIOD       = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                sysid_address,
    input  logic [DATA_W-1:0]   sysid_readdata,
    output logic                busy,
    output logic                done,
    output logic                id_ok,
    output logic                ts_ok,
    output logic [DATA_W-1:0]   captured_id,
    output logic [DATA_W-1:0]   captured_ts,
    output logic [MCOUNT_W-1:0] mismatch_count
);

    localparam logic [WAIT_CNT_W-1:0] LAT          = WAIT_CNT_W'(READ_LATENCY);
    localparam logic [MCOUNT_W-1:0]   MCOUNT_MAX   = '1;

    state_t                state, state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [DATA_W-1:0]     id_reg, id_reg_nxt;
    check_result_t         result, result_nxt;
    logic [MCOUNT_W-1:0]   mcount, mcount_nxt;
    logic                  busy_nxt, done_nxt, addr_nxt;
    logic                  periodic_tick;
    logic                  start_c;
    logic                  wait_done_c;
    logic                  id_match_c, ts_match_c;

`ifdef SYSID_PERIODIC_CHECK_EN
    sysid_period_timer #(
        .CHECK_PERIOD (CHECK_PERIOD)
    ) u_period_timer (
        .clock (clock),
        .reset (reset),
        .tick  (periodic_tick)
    );
`else
    logic unused_check_period;
    assign periodic_tick       = 1'b0;
    assign unused_check_period = ^32'(CHECK_PERIOD);
`endif

    assign start_c     = start | periodic_tick;
    assign wait_done_c = (wait_cnt == LAT);
    assign id_match_c  = (id_reg == EXPECTED_ID);
    assign ts_match_c  = (sysid_readdata == EXPECTED_TIMESTAMP);

    // Next-state, capture and output decode.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        id_reg_nxt   = id_reg;
        result_nxt   = result;
        mcount_nxt   = mcount;

        case (state)
            IDLE: begin
                if (start_c) begin
                    state_nxt    = RD_ID;
                    wait_cnt_nxt = '0;
                end
            end
            RD_ID: begin
                if (wait_done_c) begin
                    id_reg_nxt   = sysid_readdata;
                    wait_cnt_nxt = '0;
                    state_nxt    = RD_TS;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
                end
            end
            RD_TS: begin
                if (wait_done_c) begin
                    result_nxt.id    = id_reg;
                    result_nxt.ts    = sysid_readdata;
                    result_nxt.id_ok = id_match_c;
                    result_nxt.ts_ok = ts_match_c;
                    if (!(id_match_c && ts_match_c) && (mcount != MCOUNT_MAX)) begin
                        mcount_nxt = mcount + MCOUNT_W'(1);
                    end
                    wait_cnt_nxt = '0;
                    state_nxt    = REPORT;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == RD_ID) || (state_nxt == RD_TS);
        done_nxt = (state_nxt == REPORT);
        addr_nxt = (state_nxt == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    end

    // State and registered outputs; reset aborts any check in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            id_reg        <= '0;
            result        <= '0;
            mcount        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sysid_address <= SYSID_ADDR_ID;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            id_reg        <= id_reg_nxt;
            result        <= result_nxt;
            mcount        <= mcount_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            sysid_address <= addr_nxt;
        end
    end

    assign captured_id    = result.id;
    assign captured_ts    = result.ts;
    assign id_ok          = result.id_ok;
    assign ts_ok          = result.ts_ok;
    assign mismatch_count = mcount;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench: dut0 uses READ_LATENCY=0, dut1 uses READ_LATENCY=3 with
// a slave whose data is only valid 3 cycles after an address change.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1490127728;

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic        id_ok;
        logic        ts_ok;
        logic [7:0]  mc;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic        addr0, addr1;
    logic [31:0] rd0, rd1;
    logic        busy0, busy1, done0, done1;
    logic        iok0, iok1, tok0, tok1;
    logic [31:0] cid0, cid1, cts0, cts1;
    logic [7:0]  mc0_o, mc1_o;

    logic [31:0] id0, ts0, id1, ts1;
    logic [2:0]  hist1 = 3'b000;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          mc0 = 0;
    int          mc1 = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) hist1 <= {hist1[1:0], addr1};

    assign rd0 = addr0 ? ts0 : id0;
    assign rd1 = (hist1[2] == addr1) ? (addr1 ? ts1 : id1) : 32'hDEADBEEF;

    sysid_boot_checker dut0 (
        .clock          (clk),
        .reset          (reset),
        .start          (start0),
        .sysid_address  (addr0),
        .sysid_readdata (rd0),
        .busy           (busy0),
        .done           (done0),
        .id_ok          (iok0),
        .ts_ok          (tok0),
        .captured_id    (cid0),
        .captured_ts    (cts0),
        .mismatch_count (mc0_o)
    );

    sysid_boot_checker #(.READ_LATENCY(3)) dut1 (
        .clock          (clk),
        .reset          (reset),
        .start          (start1),
        .sysid_address  (addr1),
        .sysid_readdata (rd1),
        .busy           (busy1),
        .done           (done1),
        .id_ok          (iok1),
        .ts_ok          (tok1),
        .captured_id    (cid1),
        .captured_ts    (cts1),
        .mismatch_count (mc1_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int bump(input int mc, input logic ok);
        if (ok) return mc;
        return (mc < 255) ? mc + 1 : 255;
    endfunction

    task automatic push0();
        exp_t e;
        e.id = id0; e.ts = ts0;
        e.id_ok = (id0 == EXP_ID);
        e.ts_ok = (ts0 == EXP_TS);
        mc0 = bump(mc0, e.id_ok && e.ts_ok);
        e.mc = 8'(mc0);
        e.done_cyc = cyc + 3;
        q0.push_back(e);
    endtask

    task automatic push1();
        exp_t e;
        e.id = id1; e.ts = ts1;
        e.id_ok = (id1 == EXP_ID);
        e.ts_ok = (ts1 == EXP_TS);
        mc1 = bump(mc1, e.id_ok && e.ts_ok);
        e.mc = 8'(mc1);
        e.done_cyc = cyc + 9;
        q1.push_back(e);
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [31:0] cid,
                           input logic [31:0] cts, input logic iok, input logic tok,
                           input logic [7:0] mc, input logic bsy);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
        check({tag, "_captured_id"}, cid, e.id);
        check({tag, "_captured_ts"}, cts, e.ts);
        check({tag, "_id_ok"}, 32'(iok), 32'(e.id_ok));
        check({tag, "_ts_ok"}, 32'(tok), 32'(e.ts_ok));
        check({tag, "_mismatch_count"}, 32'(mc), 32'(e.mc));
        check({tag, "_busy_at_done"}, 32'(bsy), 32'd0);
    endtask

    task automatic check_zero(input string tag, input logic a, input logic b, input logic d,
                              input logic io, input logic to, input logic [31:0] ci,
                              input logic [31:0] ct, input logic [7:0] mc);
        check({tag, "_outputs_zero"}, {a, b, d, io, to, 27'd0} | ci | ct | 32'(mc), 32'd0);
    endtask

    // Pops one expected result per done pulse from each DUT.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done0) begin
                if (q0.size() == 0) check("dut0_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    compare("dut0", e, cid0, cts0, iok0, tok0, mc0_o, busy0);
                end
            end
            if (done1) begin
                if (q1.size() == 0) check("dut1_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    compare("dut1", e, cid1, cts1, iok1, tok1, mc1_o, busy1);
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
        end
        check("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    task automatic issue0();
        step();
        start0 = 1'b1;
        push0();
        step();
        start0 = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        id0 = EXP_ID; ts0 = EXP_TS; id1 = EXP_ID; ts1 = EXP_TS;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check_zero("reset_dut0", addr0, busy0, done0, iok0, tok0, cid0, cts0, mc0_o);
        check_zero("reset_dut1", addr1, busy1, done1, iok1, tok1, cid1, cts1, mc1_o);

        // Matching read, latency 0: addr 0 in cycle 1, addr 1 in cycle 2, done in cycle 3.
        issue0();
        @(negedge clk);
        check("rl0_addr_c1", 32'(addr0), 32'd0);
        check("rl0_busy_c1", 32'(busy0), 32'd1);
        @(negedge clk);
        check("rl0_addr_c2", 32'(addr0), 32'd1);
        wait_drain();

        // Timestamp off by one, then saturation of the mismatch counter.
        ts0 = EXP_TS + 32'd1;
        issue0();
        wait_drain();
        for (int n = 0; n < 300; n++) begin
            issue0();
            wait_drain();
        end
        @(negedge clk);
        check("mismatch_saturated", 32'(mc0_o), 32'd255);

        // Latency 3: addr 0 for cycles 1-4, addr 1 for cycles 5-8, done at 9.
        step();
        start1 = 1'b1;
        push1();
        step();
        start1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("rl3_addr_c%0d", i), 32'(addr1), (i >= 5) ? 32'd1 : 32'd0);
            check($sformatf("rl3_busy_c%0d", i), 32'(busy1), 32'd1);
        end
        wait_drain();
        id1 = 32'hCAFE0001;
        repeat (4) step();
        start1 = 1'b1;
        push1();
        step();
        start1 = 1'b0;
        wait_drain();

        // Starts in cycles 1 and 2 are ignored; results hold until REPORT.
        id0 = 32'h00001234; ts0 = EXP_TS;
        step();
        start0 = 1'b1;
        push0();
        step();
        step();
        @(negedge clk);
        check("hold_captured_ts", cts0, EXP_TS + 32'd1);
        check("hold_captured_id", cid0, EXP_ID);
        check("hold_ts_ok", 32'(tok0), 32'd0);
        step();
        start0 = 1'b0;
        wait_drain();
        repeat (10) step();

        // Reset in cycle 2 of a check aborts it and clears everything.
        id0 = EXP_ID; ts0 = EXP_TS;
        step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        reset = 1'b1;
        mc0 = 0; mc1 = 0;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_zero("abort_dut0", addr0, busy0, done0, iok0, tok0, cid0, cts0, mc0_o);
        check_zero("abort_dut1", addr1, busy1, done1, iok1, tok1, cid1, cts1, mc1_o);
        repeat (8) step();
        issue0();
        wait_drain();

        // start held high: checks complete at +3, +7, +11.
        step();
        start0 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            push0();
            if (j < 2) repeat (4) step();
        end
        step();
        start0 = 1'b0;
        wait_drain();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
